traffic_light_controller_fsm: RTL and testbench
===============================================

Name: traffic_light_controller_fsm

Overview:
- Control FSM for the two-way (main/side street) traffic light controller.
- Sits directly upstream of the 5-bit timer datapath:
  - drives the timer's `max_count` and a one-cycle `timer_clear`;
  - consumes the timer's registered `count_done`.
- Sequences the light phases, latches side-street car and pedestrian requests, and drives the lamp and walk outputs.

Parameters:
- MAIN_GREEN_T, 20, main green dwell count (5-bit, 0..31)
- SIDE_GREEN_T, 10, side green dwell count
- YELLOW_T, 3, yellow dwell count (both directions)
- ALL_RED_T, 1, all-red clearance dwell count

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- car_side  input  1  side-street vehicle sensor, level
- ped_btn  input  1  pedestrian push-button, level
- count_done  input  1  registered done flag from timer datapath
- max_count  output  5  terminal count for the current phase, registered
- timer_clear  output  1  one-cycle synchronous restart pulse to timer, registered
- main_lights  output  3  {red,yellow,green} one-hot, main street, registered
- side_lights  output  3  {red,yellow,green} one-hot, side street, registered
- ped_walk  output  1  walk lamp for crossing main street, registered

Behaviour:
- Interface: one clock `clk`; reset `reset` is asynchronous and active-high. All outputs are registered.
- Timer contract:
  - `timer_clear` has priority over counting; it sets cntr=0 and count_done=0 at the next edge.
  - The timer then counts 0..max_count; count_done rises one edge after cntr==max_count and holds.
- States, in order: MAIN_GREEN, MAIN_YELLOW, ALL_RED_A, SIDE_GREEN, SIDE_YELLOW, ALL_RED_B, then back to MAIN_GREEN. Encoding is 3-bit binary, with values 0..5 in that order.
- Phase entry:
  - On every state entry, `timer_clear`=1 for exactly the first cycle in the state.
  - `max_count` takes the phase's parameter in that same cycle.
- count_done qualification: count_done is ignored in any cycle where `timer_clear`=1, which masks the stale flag from the previous phase.
- Dwell: each timed phase lasts exactly T+3 cycles: 1 clear cycle, T+1 count cycles, 1 done-seen cycle. The transition occurs at the end of the first qualified count_done=1 cycle.
- MAIN_GREEN exit:
  - Leaves only when count_done is qualified AND (side_req OR ped_req).
  - Otherwise it holds with no re-clear. count_done stays high, so the exit happens in the first cycle a request is present.
- Request latches:
  - side_req is set by car_side=1; ped_req is set by ped_btn=1.
  - Both are sticky and cleared on entry to SIDE_GREEN.
  - A request asserted in the SIDE_GREEN entry cycle is captured: set wins over clear.
- Lamps:
  - MAIN_GREEN: main=G, side=R.
  - MAIN_YELLOW: main=Y, side=R.
  - ALL_RED_A and ALL_RED_B: both R.
  - SIDE_GREEN: main=R, side=G.
  - SIDE_YELLOW: main=R, side=Y.
  - Both directions are never non-red simultaneously. This is an assertion target.
- ped_walk is 1 only during SIDE_GREEN, and only if ped_req was set when SIDE_GREEN was entered. That value is captured in a flag at entry.
- Reset values:
  - state=ALL_RED_B, main_lights=3'b100, side_lights=3'b100, ped_walk=0.
  - max_count=ALL_RED_T, timer_clear=1, side_req=0, ped_req=0.
  - The first cycle after reset release therefore restarts the timer.
- Reset mid-phase: asynchronously forces the reset values; the phase in progress is abandoned.
- Width rules: parameters are checked at elaboration to be ≤31 (`$error` otherwise). max_count is truncated to 5 bits.

Decomposition:
- Shared package `tlc_pkg`:
  - state enum/localparams;
  - lamp encodings LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001;
  - default phase-time constants.
- No sub-module; the request latches stay inline.
- A top `traffic_light_controller` instantiates this FSM plus the timer datapath.

Test Plan:
- Reset, then release with no requests → ALL_RED_B for 4 cycles (T=1 → 1+3), then MAIN_GREEN. After 23 cycles count_done is qualified, and the FSM holds MAIN_GREEN indefinitely with timer_clear=0.
- car_side pulsed for 1 cycle at cycle 5 of MAIN_GREEN → exit at cycle 23, then:
  - MAIN_YELLOW 6 cycles, ALL_RED_A 4 cycles, SIDE_GREEN 13 cycles, SIDE_YELLOW 6 cycles, ALL_RED_B 4 cycles;
  - ped_walk=0 throughout.
- ped_btn=1 only, while holding in MAIN_GREEN → transition on the next cycle; ped_walk=1 for all 13 SIDE_GREEN cycles; ped_req=0 afterwards.
- car_side=1 in the SIDE_GREEN entry cycle → side_req=1 after entry. The next MAIN_GREEN exits at its count_done (cycle 23).
- reset asserted mid-SIDE_GREEN (cycle 7) → same-cycle async return to ALL_RED_B, both lamps red, timer_clear=1, max_count=1.
- Every cycle of all tests: assert exactly one lamp bit per direction, never main≠R && side≠R, and timer_clear high for exactly 1 cycle per state entry.

Source files
------------

// File: rtl/tlc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tlc_pkg
// Purpose  : Shared types and constants for the traffic light controller:
//            phase state encoding, lamp encodings, default phase times.
// Revision : 1.0  initial release
// ============================================================================
package tlc_pkg;

    // Phase states, visited in declaration order and wrapping back to MAIN_GREEN.
    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_B   = 3'd5
    } tlc_state_e;

    // Lamp encodings, {red,yellow,green} one-hot.
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // Default dwell counts.
    localparam int DEF_MAIN_GREEN_T = 20;
    localparam int DEF_SIDE_GREEN_T = 10;
    localparam int DEF_YELLOW_T     = 3;
    localparam int DEF_ALL_RED_T    = 1;

    // Lamp pattern for a state, returned as {main, side}.
    function automatic logic [5:0] lamps_for(input tlc_state_e s);
        logic [5:0] l;
        l = {LAMP_RED, LAMP_RED};
        case (s)
            MAIN_GREEN:  l = {LAMP_GRN, LAMP_RED};
            MAIN_YELLOW: l = {LAMP_YEL, LAMP_RED};
            SIDE_GREEN:  l = {LAMP_RED, LAMP_GRN};
            SIDE_YELLOW: l = {LAMP_RED, LAMP_YEL};
            default:     l = {LAMP_RED, LAMP_RED};
        endcase
        return l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_light_controller_fsm.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_controller_fsm
// Purpose  : Phase sequencer for a main/side street intersection. Drives the
//            timer's terminal count and restart pulse, latches side-street
//            car and pedestrian requests, and drives lamps and walk signal.
// Revision : 1.0  initial release
// ============================================================================
module traffic_light_controller_fsm
    import tlc_pkg::*;
#(
    parameter int MAIN_GREEN_T = DEF_MAIN_GREEN_T,
    parameter int SIDE_GREEN_T = DEF_SIDE_GREEN_T,
    parameter int YELLOW_T     = DEF_YELLOW_T,
    parameter int ALL_RED_T    = DEF_ALL_RED_T
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_side,
    input  logic       ped_btn,
    input  logic       count_done,
    output logic [4:0] max_count,
    output logic       timer_clear,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       ped_walk
);

    // Phase times must fit the 5-bit timer.
    generate
        if (MAIN_GREEN_T > 31 || SIDE_GREEN_T > 31 || YELLOW_T > 31 || ALL_RED_T > 31)
        begin : g_param_check
            $error("traffic_light_controller_fsm: phase time parameter exceeds 31");
        end
    endgenerate

    localparam logic [4:0] C_MG_T = 5'(MAIN_GREEN_T);
    localparam logic [4:0] C_SG_T = 5'(SIDE_GREEN_T);
    localparam logic [4:0] C_Y_T  = 5'(YELLOW_T);
    localparam logic [4:0] C_AR_T = 5'(ALL_RED_T);

    tlc_state_e state_q, state_d;
    logic [4:0] max_count_q, max_count_d;
    logic       timer_clear_q, timer_clear_d;
    logic [2:0] main_q, main_d;
    logic [2:0] side_q, side_d;
    logic       ped_walk_q, ped_walk_d;
    logic       side_req_q, side_req_d;
    logic       ped_req_q, ped_req_d;

    logic       w_done;
    logic       w_enter;
    logic       w_sg_entry;

    // The done flag is stale during the clear cycle, so it is masked there.
    assign w_done     = count_done & ~timer_clear_q;
    assign w_sg_entry = (state_q == SIDE_GREEN) & timer_clear_q;

    // Next state, registered outputs and request latches.
    always_comb begin
        state_d       = state_q;
        max_count_d   = max_count_q;
        timer_clear_d = 1'b0;
        main_d        = main_q;
        side_d        = side_q;
        ped_walk_d    = 1'b0;
        side_req_d    = side_req_q;
        ped_req_d     = ped_req_q;
        w_enter       = 1'b0;

        case (state_q)
            MAIN_GREEN:  if (w_done && (side_req_q || ped_req_q)) state_d = MAIN_YELLOW;
            MAIN_YELLOW: if (w_done) state_d = ALL_RED_A;
            ALL_RED_A:   if (w_done) state_d = SIDE_GREEN;
            SIDE_GREEN:  if (w_done) state_d = SIDE_YELLOW;
            SIDE_YELLOW: if (w_done) state_d = ALL_RED_B;
            ALL_RED_B:   if (w_done) state_d = MAIN_GREEN;
            default:     state_d = ALL_RED_B;
        endcase

        w_enter       = (state_d != state_q);
        timer_clear_d = w_enter;

        case (state_d)
            MAIN_GREEN:               max_count_d = C_MG_T;
            SIDE_GREEN:               max_count_d = C_SG_T;
            MAIN_YELLOW, SIDE_YELLOW: max_count_d = C_Y_T;
            default:                  max_count_d = C_AR_T;
        endcase

        {main_d, side_d} = lamps_for(state_d);

        // Walk is decided once at SIDE_GREEN entry and held for the phase.
        if (state_d == SIDE_GREEN)
            ped_walk_d = w_enter ? (ped_req_q | ped_btn) : ped_walk_q;

        // Sticky requests, cleared in the SIDE_GREEN entry cycle; a new
        // request in that same cycle survives the clear.
        side_req_d = car_side | (side_req_q & ~w_sg_entry);
        ped_req_d  = ped_btn  | (ped_req_q  & ~w_sg_entry);
    end

    // State and output registers with asynchronous reset to ALL_RED_B.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ALL_RED_B;
            max_count_q   <= C_AR_T;
            timer_clear_q <= 1'b1;
            main_q        <= LAMP_RED;
            side_q        <= LAMP_RED;
            ped_walk_q    <= 1'b0;
            side_req_q    <= 1'b0;
            ped_req_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            max_count_q   <= max_count_d;
            timer_clear_q <= timer_clear_d;
            main_q        <= main_d;
            side_q        <= side_d;
            ped_walk_q    <= ped_walk_d;
            side_req_q    <= side_req_d;
            ped_req_q     <= ped_req_d;
        end
    end

    assign max_count   = max_count_q;
    assign timer_clear = timer_clear_q;
    assign main_lights = main_q;
    assign side_lights = side_q;
    assign ped_walk    = ped_walk_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_controller_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_controller_fsm
// Purpose  : Directed bench for the traffic light FSM with a behavioural
//            5-bit timer closing the count_done loop.
// Revision : 1.0  initial release
// ============================================================================
module tb_traffic_light_controller_fsm;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk = 1'b0;
    logic       reset;
    logic       car_side;
    logic       ped_btn;
    logic       count_done;
    logic [4:0] max_count;
    logic       timer_clear;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       ped_walk;

    int checks = 0;
    int errors = 0;

    logic [4:0] cntr;
    logic [5:0] prev_lamps;
    logic       prev_valid = 1'b0;

    traffic_light_controller_fsm u_dut (
        .clk        (clk),
        .reset      (reset),
        .car_side   (car_side),
        .ped_btn    (ped_btn),
        .count_done (count_done),
        .max_count  (max_count),
        .timer_clear(timer_clear),
        .main_lights(main_lights),
        .side_lights(side_lights),
        .ped_walk   (ped_walk)
    );

    always #5 clk = ~clk;

    // Timer datapath model: clear has priority, counts 0..max, done sticks.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cntr       <= 5'd0;
            count_done <= 1'b0;
        end else if (timer_clear) begin
            cntr       <= 5'd0;
            count_done <= 1'b0;
        end else if (cntr == max_count) begin
            count_done <= 1'b1;
        end else begin
            cntr <= cntr + 5'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check lamps/walk/max_count for n consecutive cycles, sampling at negedge.
    task automatic phase(input string tag, input logic [2:0] m, input logic [2:0] s,
                         input logic w, input int n, input logic [4:0] mc);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_main"}, main_lights, m);
            chk({tag, "_side"}, side_lights, s);
            chk({tag, "_walk"}, ped_walk, w);
            chk({tag, "_max"},  max_count, mc);
            @(negedge clk);
        end
    endtask

    // Every-cycle invariants: one-hot lamps, no conflicting greens, and a
    // timer_clear exactly in the first cycle of each phase (every phase
    // change alters at least one lamp).
    always begin
        @(posedge clk);
        #3;
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            chk("main_onehot", $countones(main_lights), 1);
            chk("side_onehot", $countones(side_lights), 1);
            chk("conflict", (main_lights != R) && (side_lights != R), 0);
            if (prev_valid)
                chk("clear_on_entry", timer_clear, {main_lights, side_lights} != prev_lamps);
            else
                chk("clear_after_reset", timer_clear, 1);
            prev_lamps = {main_lights, side_lights};
            prev_valid = 1'b1;
        end
    end

    initial begin
        reset    = 1'b1;
        car_side = 1'b0;
        ped_btn  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_main",  main_lights, R);
        chk("rst_side",  side_lights, R);
        chk("rst_walk",  ped_walk, 0);
        chk("rst_max",   max_count, 5'd1);
        chk("rst_clear", timer_clear, 1);

        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);

        // Startup and indefinite MAIN_GREEN hold with no requests.
        phase("arb0",    R, R, 0, 4, 5'd1);
        phase("mg_hold", G, R, 0, 30, 5'd20);

        // Pedestrian request while holding: exit on the next cycle.
        ped_btn = 1'b1;
        phase("mg_ped",  G, R, 0, 1, 5'd20);
        ped_btn = 1'b0;
        phase("mg_ped2", G, R, 0, 1, 5'd20);
        phase("my1",     Y, R, 0, 6, 5'd3);
        phase("ara1",    R, R, 0, 4, 5'd1);
        // Car request in SIDE_GREEN entry cycle must survive the clear.
        car_side = 1'b1;
        phase("sg1a",    R, G, 1, 1, 5'd10);
        car_side = 1'b0;
        phase("sg1b",    R, G, 1, 12, 5'd10);
        phase("sy1",     R, Y, 0, 6, 5'd3);
        phase("arb1",    R, R, 0, 4, 5'd1);

        // Captured side_req: exits at count_done, no walk (ped_req cleared).
        phase("mg2",     G, R, 0, 23, 5'd20);
        phase("my2",     Y, R, 0, 6, 5'd3);
        phase("ara2",    R, R, 0, 4, 5'd1);
        phase("sg2",     R, G, 0, 13, 5'd10);
        phase("sy2",     R, Y, 0, 6, 5'd3);
        phase("arb2",    R, R, 0, 4, 5'd1);

        // One-cycle car pulse at cycle 5 of MAIN_GREEN.
        phase("mg3a",    G, R, 0, 5, 5'd20);
        car_side = 1'b1;
        phase("mg3b",    G, R, 0, 1, 5'd20);
        car_side = 1'b0;
        phase("mg3c",    G, R, 0, 17, 5'd20);
        phase("my3",     Y, R, 0, 6, 5'd3);
        phase("ara3",    R, R, 0, 4, 5'd1);
        phase("sg3",     R, G, 0, 13, 5'd10);
        phase("sy3",     R, Y, 0, 6, 5'd3);
        phase("arb3",    R, R, 0, 4, 5'd1);
        phase("mg4",     G, R, 0, 30, 5'd20);

        // Reset in the middle of SIDE_GREEN.
        ped_btn = 1'b1;
        phase("mg4p",    G, R, 0, 1, 5'd20);
        ped_btn = 1'b0;
        phase("mg4q",    G, R, 0, 1, 5'd20);
        phase("my4",     Y, R, 0, 6, 5'd3);
        phase("ara4",    R, R, 0, 4, 5'd1);
        phase("sg4",     R, G, 1, 7, 5'd10);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_main",  main_lights, R);
        chk("mid_rst_side",  side_lights, R);
        chk("mid_rst_walk",  ped_walk, 0);
        chk("mid_rst_max",   max_count, 5'd1);
        chk("mid_rst_clear", timer_clear, 1);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        phase("arb5",    R, R, 0, 4, 5'd1);
        phase("mg5",     G, R, 0, 25, 5'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
